// File: rtl/pulse_handshake_rx_pkg.sv
// Shared definitions for the 4-phase pulse-handshake CDC pair.
// The source-side block uses the same state encoding and defaults.
package pulse_handshake_rx_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PULSE  = 2'd1,
    ACK_HI = 2'd2
  } hs_state_e;

  localparam int unsigned DEF_SYNC_STAGES = 2;
  localparam int unsigned DEF_PULSE_WIDTH = 1;
  localparam int unsigned DEF_CNT_W       = 8;

endpackage

// File: rtl/pulse_handshake_rx_if.sv
// Handshake and status signals of the destination-side responder.
interface pulse_handshake_rx_if
  import pulse_handshake_rx_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W
);

  logic             req_async;
  logic             ready;
  logic             ack;
  logic             pulse_out;
  logic             busy;
  logic [CNT_W-1:0] evt_cnt;
  logic             err_proto;

  modport master (
    output req_async, ready,
    input  ack, pulse_out, busy, evt_cnt, err_proto
  );

  modport slave (
    input  req_async, ready,
    output ack, pulse_out, busy, evt_cnt, err_proto
  );

endinterface

// File: rtl/cdc_sync_level.sv
// Plain level synchronizer: a flop chain with synchronous reset.
module cdc_sync_level
  import pulse_handshake_rx_pkg::*;
#(
  parameter int unsigned STAGES = DEF_SYNC_STAGES
) (
  input  logic clk_b,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk_b) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  assign q = r_sync[STAGES-1];

endmodule

// File: rtl/pulse_handshake_rx.sv
// Destination-side responder of the 4-phase req/ack handshake: synchronizes
// the request, emits a fixed-width event pulse and returns a level ack.
module pulse_handshake_rx
  import pulse_handshake_rx_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int unsigned PULSE_WIDTH = DEF_PULSE_WIDTH,
  parameter int unsigned CNT_W       = DEF_CNT_W
) (
  input  logic                 clk_b,
  input  logic                 rst,
  pulse_handshake_rx_if.slave  bus
);

  localparam int unsigned WCNT_W = (PULSE_WIDTH > 1) ? $clog2(PULSE_WIDTH) : 1;
  localparam logic [WCNT_W-1:0] WCNT_LOAD = WCNT_W'(PULSE_WIDTH - 1);

  hs_state_e         r_state, w_state_nxt;
  logic              w_req_pre;
  logic              r_req_sync;
  logic              r_ack, w_ack_nxt;
  logic              r_pulse, w_pulse_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_err, w_err_nxt;
  logic [CNT_W-1:0]  r_evt_cnt, w_evt_cnt_nxt;
  logic [WCNT_W-1:0] r_wcnt, w_wcnt_nxt;

  // Last synchronizer stage lives here so busy can look one stage ahead.
  cdc_sync_level #(
    .STAGES (SYNC_STAGES - 1)
  ) u_sync (
    .clk_b (clk_b),
    .rst   (rst),
    .d     (bus.req_async),
    .q     (w_req_pre)
  );

  always_ff @(posedge clk_b) begin
    if (rst) begin
      r_req_sync <= 1'b0;
      r_state    <= IDLE;
      r_ack      <= 1'b0;
      r_pulse    <= 1'b0;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
      r_evt_cnt  <= '0;
      r_wcnt     <= '0;
    end else begin
      r_req_sync <= w_req_pre;
      r_state    <= w_state_nxt;
      r_ack      <= w_ack_nxt;
      r_pulse    <= w_pulse_nxt;
      r_busy     <= w_busy_nxt;
      r_err      <= w_err_nxt;
      r_evt_cnt  <= w_evt_cnt_nxt;
      r_wcnt     <= w_wcnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_ack_nxt     = r_ack;
    w_pulse_nxt   = r_pulse;
    w_err_nxt     = r_err;
    w_evt_cnt_nxt = r_evt_cnt;
    w_wcnt_nxt    = r_wcnt;

    unique case (r_state)
      IDLE: begin
        if (r_req_sync && bus.ready) begin
          w_state_nxt   = PULSE;
          w_pulse_nxt   = 1'b1;
          w_wcnt_nxt    = WCNT_LOAD;
          w_evt_cnt_nxt = r_evt_cnt + CNT_W'(1);
        end
      end
      PULSE: begin
        // A request withdrawn while the pulse is running is a violation,
        // but the pulse always runs to full width.
        if (!r_req_sync) begin
          w_err_nxt = 1'b1;
        end
        if (r_wcnt == '0) begin
          w_pulse_nxt = 1'b0;
          if (r_req_sync) begin
            w_ack_nxt   = 1'b1;
            w_state_nxt = ACK_HI;
          end else begin
            w_state_nxt = IDLE;
          end
        end else begin
          w_wcnt_nxt = r_wcnt - WCNT_W'(1);
        end
      end
      ACK_HI: begin
        if (!r_req_sync) begin
          w_ack_nxt   = 1'b0;
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    w_busy_nxt = (w_state_nxt != IDLE) | w_req_pre;
  end

  assign bus.ack       = r_ack;
  assign bus.pulse_out = r_pulse;
  assign bus.busy      = r_busy;
  assign bus.evt_cnt   = r_evt_cnt;
  assign bus.err_proto = r_err;

endmodule

// File: tb/tb_pulse_handshake_rx.sv
// Randomized scoreboard bench for pulse_handshake_rx: two configurations
// driven by independent source agents, checked every cycle against a model.
module tb_pulse_handshake_rx;

  localparam int unsigned S0 = 2, PW0 = 1, CW0 = 8;
  localparam int unsigned S1 = 3, PW1 = 4, CW1 = 2;
  localparam int NCYC    = 6000;
  localparam int TIMEOUT = 100;

  typedef struct packed {
    logic       ack;
    logic       pulse;
    logic       busy;
    logic       err;
    logic [7:0] cnt;
  } obs_t;

  logic clk_b = 1'b0;
  logic rst;

  always #10 clk_b = ~clk_b;

  pulse_handshake_rx_if #(.CNT_W(CW0)) bus0 ();
  pulse_handshake_rx_if #(.CNT_W(CW1)) bus1 ();

  pulse_handshake_rx #(.SYNC_STAGES(S0), .PULSE_WIDTH(PW0), .CNT_W(CW0)) dut0 (
    .clk_b (clk_b),
    .rst   (rst),
    .bus   (bus0.slave)
  );

  pulse_handshake_rx #(.SYNC_STAGES(S1), .PULSE_WIDTH(PW1), .CNT_W(CW1)) dut1 (
    .clk_b (clk_b),
    .rst   (rst),
    .bus   (bus1.slave)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  obs_t exp_q0[$];
  obs_t exp_q1[$];

  // Reference model: request history, remaining pulse cycles, ack level.
  bit m_hist[2][8];
  int m_left[2];
  bit m_ack[2];
  bit m_err[2];
  int m_cnt[2];

  // Source agent state.
  int src_phase[2];
  int src_timer[2];
  int src_wait[2];
  bit src_viol[2];

  task automatic model_step(input int k, input int stages, input int pw, input int cw,
                            input logic rq, input logic rdy, input logic rs);
    bit rsync;
    rsync = m_hist[k][stages-1];
    if (rs) begin
      for (int i = 0; i < 8; i++) m_hist[k][i] = 1'b0;
      m_left[k] = 0;
      m_ack[k]  = 1'b0;
      m_err[k]  = 1'b0;
      m_cnt[k]  = 0;
    end else begin
      if (m_left[k] > 0) begin
        if (!rsync) m_err[k] = 1'b1;
        m_left[k] = m_left[k] - 1;
        if (m_left[k] == 0) m_ack[k] = rsync;
      end else if (m_ack[k]) begin
        if (!rsync) m_ack[k] = 1'b0;
      end else if (rsync && rdy) begin
        m_left[k] = pw;
        m_cnt[k]  = (m_cnt[k] + 1) % (1 << cw);
      end
      for (int i = stages - 1; i > 0; i--) m_hist[k][i] = m_hist[k][i-1];
      m_hist[k][0] = rq;
    end
  endtask

  function automatic obs_t model_obs(input int k, input int stages);
    obs_t o;
    o.pulse = (m_left[k] > 0);
    o.ack   = m_ack[k];
    o.busy  = (m_left[k] > 0) || m_ack[k] || m_hist[k][stages-1];
    o.err   = m_err[k];
    o.cnt   = 8'(m_cnt[k]);
    return o;
  endfunction

  // Well-behaved source most of the time; occasionally withdraws early.
  task automatic src_next(input int k, input logic ack_obs, output logic rq);
    rq = 1'b0;
    case (src_phase[k])
      0: begin
        if (src_timer[k] <= 0) begin
          rq           = 1'b1;
          src_phase[k] = 1;
          src_viol[k]  = ($urandom_range(0, 7) == 0);
          src_timer[k] = $urandom_range(1, 5);
          src_wait[k]  = 0;
        end else begin
          src_timer[k] = src_timer[k] - 1;
        end
      end
      1: begin
        rq          = 1'b1;
        src_wait[k] = src_wait[k] + 1;
        if (src_viol[k]) begin
          if (src_timer[k] <= 1) begin
            rq           = 1'b0;
            src_phase[k] = 2;
          end else begin
            src_timer[k] = src_timer[k] - 1;
          end
        end else if (ack_obs) begin
          checks++;
          rq           = 1'b0;
          src_phase[k] = 2;
        end else if (src_wait[k] > TIMEOUT) begin
          checks++;
          errors++;
          $display("FAIL ack_timeout dut%0d cyc=%0d: ack=0 after %0d cycles, required 1",
                   k, cyc, src_wait[k]);
          rq           = 1'b0;
          src_phase[k] = 2;
        end
      end
      default: begin
        if (!ack_obs) begin
          src_phase[k] = 0;
          src_timer[k] = $urandom_range(0, 6);
        end
      end
    endcase
  endtask

  task automatic check(input string name, input obs_t got, input obs_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d: got ack=%b pulse=%b busy=%b err=%b cnt=%0d, required ack=%b pulse=%b busy=%b err=%b cnt=%0d",
               name, cyc, got.ack, got.pulse, got.busy, got.err, got.cnt,
               exp.ack, exp.pulse, exp.busy, exp.err, exp.cnt);
    end
  endtask

  // Monitor: compare each presented output snapshot against the scoreboard.
  initial begin
    obs_t g, e;
    forever begin
      @(negedge clk_b);
      if (exp_q0.size() > 0) begin
        e = exp_q0.pop_front();
        g = {bus0.ack, bus0.pulse_out, bus0.busy, bus0.err_proto, 8'(bus0.evt_cnt)};
        check("dut0", g, e);
      end
      if (exp_q1.size() > 0) begin
        e = exp_q1.pop_front();
        g = {bus1.ack, bus1.pulse_out, bus1.busy, bus1.err_proto, 8'(bus1.evt_cnt)};
        check("dut1", g, e);
      end
    end
  end

  // Stimulus: drive inputs just after each edge, then advance the model.
  initial begin
    logic rq0, rq1;
    rst            = 1'b1;
    bus0.req_async = 1'b0;
    bus0.ready     = 1'b0;
    bus1.req_async = 1'b0;
    bus1.ready     = 1'b0;
    for (int k = 0; k < 2; k++) begin
      src_phase[k] = 0;
      src_timer[k] = 2;
      src_wait[k]  = 0;
      src_viol[k]  = 1'b0;
      m_left[k]    = 0;
      m_ack[k]     = 1'b0;
      m_err[k]     = 1'b0;
      m_cnt[k]     = 0;
      for (int i = 0; i < 8; i++) m_hist[k][i] = 1'b0;
    end

    for (int c = 0; c < NCYC; c++) begin
      cyc = c;
      rst = (c < 3) || ($urandom_range(0, 499) == 0);
      src_next(0, bus0.ack, rq0);
      src_next(1, bus1.ack, rq1);
      bus0.req_async = rq0;
      bus1.req_async = rq1;
      if ((c % 200) < 10) begin
        bus0.ready = 1'b0;
        bus1.ready = 1'b0;
      end else begin
        bus0.ready = ($urandom_range(0, 3) != 0);
        bus1.ready = ($urandom_range(0, 3) != 0);
      end
      @(posedge clk_b);
      model_step(0, S0, PW0, CW0, bus0.req_async, bus0.ready, rst);
      model_step(1, S1, PW1, CW1, bus1.req_async, bus1.ready, rst);
      exp_q0.push_back(model_obs(0, S0));
      exp_q1.push_back(model_obs(1, S1));
      #1;
    end

    repeat (2) @(negedge clk_b);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
